lc3_pipe_controller: RTL and testbench

Pipeline controller for the LC3 core. Generates per-stage enables for fetch, decode, execute and writeback, sequences the data-memory access state machine for loads and stores, inserts control-hazard bubbles after branches and jumps, and flags ALU-to-ALU operand forwarding. It consumes the decode-stage instruction (the `IR` on the decode output bus) and the execute-stage instruction, and it owns `out_enable_decode` timing.

---
 rtl/lc3_pipe_controller.sv | 216 +++++++++++++++++++++
 tb/tb_lc3_pipe_controller.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_pipe_controller.sv
// LC3 pipeline controller: stage enables, data-memory access FSM, control-hazard bubbles, ALU forwarding.
// Optional feature macro: LC3_CTRL_BYPASS_EN (forwarding); when undefined a RAW match costs one fetch/decode bubble.
module lc3_pipe_controller #(
    parameter int CTRL_BUBBLES = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        complete_instr,
    input  logic        complete_data,
    input  logic [15:0] IMem_dout,
    input  logic [15:0] IR,
    input  logic [15:0] IR_Exec,
    input  logic [2:0]  psr,
    output logic        enable_updatePC,
    output logic        enable_fetch,
    output logic        enable_decode,
    output logic        enable_execute,
    output logic        enable_writeback,
    output logic        br_taken,
    output logic        bypass_alu_1,
    output logic        bypass_alu_2,
    output logic [1:0]  mem_state
);

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LEA = 4'b1110;
    localparam logic [2:0] BUBBLE_LOAD = 3'(CTRL_BUBBLES);

    typedef enum logic [1:0] {
        MEM_READ     = 2'b00,
        MEM_WRITE    = 2'b01,
        MEM_INDIRECT = 2'b10,
        MEM_IDLE     = 2'b11
    } mem_state_t;

    mem_state_t  mem_state_r, mem_next_s;
    logic        mem_served_r, mem_served_next_s;
    logic [2:0]  bubble_cnt_r, bubble_cnt_next_s;
    logic [15:9] ctrl_ir_r, ctrl_ir_next_s;
    logic        raw_bubble_r, raw_bubble_next_s;
    logic        mem_stall_s, wb_pulse_s, ctrl_trig_s, ctrl_busy_s, br_cond_s;
    logic        alu_pair_s, fwd_src1_s, fwd_src2_s;
    logic        upd_pc_next_s, fetch_next_s, decode_next_s, execute_next_s;
    logic        writeback_next_s, br_next_s, byp1_next_s, byp2_next_s;
    logic        unused_bits_s;

    function automatic logic is_alu(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT) || (op == OP_LEA);
    endfunction

    function automatic logic is_ctrl(input logic [3:0] op);
        return (op == OP_BR) || (op == OP_JMP);
    endfunction

    assign mem_state     = mem_state_r;
    assign unused_bits_s = ^{IR[11:9], IR[4:3], IR_Exec[8:0], IMem_dout[8:0], raw_bubble_r};

    // Data-memory access FSM next state; IDLE exits only for a fresh instruction that just executed.
    always_comb begin
        mem_next_s = mem_state_r;
        case (mem_state_r)
            MEM_IDLE: begin
                if (enable_execute && !mem_served_r) begin
                    case (IR_Exec[15:12])
                        OP_LD, OP_LDR:  mem_next_s = MEM_READ;
                        OP_ST, OP_STR:  mem_next_s = MEM_WRITE;
                        OP_LDI, OP_STI: mem_next_s = MEM_INDIRECT;
                        default:        mem_next_s = MEM_IDLE;
                    endcase
                end else begin
                    mem_next_s = MEM_IDLE;
                end
            end
            MEM_READ, MEM_WRITE: begin
                if (complete_data) begin
                    mem_next_s = MEM_IDLE;
                end else begin
                    mem_next_s = mem_state_r;
                end
            end
            MEM_INDIRECT: begin
                if (complete_data) begin
                    mem_next_s = (IR_Exec[15:12] == OP_STI) ? MEM_WRITE : MEM_READ;
                end else begin
                    mem_next_s = MEM_INDIRECT;
                end
            end
            default: mem_next_s = MEM_IDLE;
        endcase
    end

    // The stall also covers the cycle right after an access completes (load data writes back then).
    assign mem_stall_s       = (mem_state_r != MEM_IDLE) || (mem_next_s != MEM_IDLE);
    assign wb_pulse_s        = (mem_state_r == MEM_READ) && (mem_next_s == MEM_IDLE);
    assign mem_served_next_s = (mem_state_r != MEM_IDLE) && (mem_next_s == MEM_IDLE);
    assign ctrl_trig_s       = enable_fetch && complete_instr && is_ctrl(IMem_dout[15:12]) && !mem_stall_s;

    // Control-bubble counter: load on a fetched BR/JMP, count down, freeze under a memory stall.
    always_comb begin
        bubble_cnt_next_s = bubble_cnt_r;
        ctrl_ir_next_s    = ctrl_ir_r;
        if (mem_stall_s) begin
            bubble_cnt_next_s = bubble_cnt_r;
        end else if (ctrl_trig_s) begin
            bubble_cnt_next_s = BUBBLE_LOAD;
            ctrl_ir_next_s    = IMem_dout[15:9];
        end else if (bubble_cnt_r != 3'd0) begin
            bubble_cnt_next_s = bubble_cnt_r - 3'd1;
        end else begin
            bubble_cnt_next_s = 3'd0;
        end
    end

    assign ctrl_busy_s = (bubble_cnt_next_s != 3'd0);
    assign br_cond_s   = (ctrl_ir_next_s[15:12] == OP_JMP) ||
                         ((ctrl_ir_next_s[15:12] == OP_BR) && (|(ctrl_ir_next_s[11:9] & psr)));

    assign alu_pair_s = is_alu(IR_Exec[15:12]) && is_alu(IR[15:12]);
    assign fwd_src1_s = alu_pair_s && (IR[8:6] == IR_Exec[11:9]);
    assign fwd_src2_s = alu_pair_s && ((IR[15:12] == OP_ADD) || (IR[15:12] == OP_AND)) &&
                        !IR[5] && (IR[2:0] == IR_Exec[11:9]);

    // RAW bubble without forwarding lasts exactly one cycle, even if the pair is still visible.
    always_comb begin
        raw_bubble_next_s = 1'b0;
`ifdef LC3_CTRL_BYPASS_EN
        raw_bubble_next_s = 1'b0;
`else
        if ((fwd_src1_s || fwd_src2_s) && !mem_stall_s && !ctrl_busy_s && !raw_bubble_r) begin
            raw_bubble_next_s = 1'b1;
        end else begin
            raw_bubble_next_s = 1'b0;
        end
`endif
    end

    // Next values of the registered enables, redirect pulse and forwarding flags.
    always_comb begin
        upd_pc_next_s    = 1'b0;
        fetch_next_s     = 1'b0;
        decode_next_s    = 1'b0;
        execute_next_s   = 1'b0;
        writeback_next_s = 1'b0;
        br_next_s        = 1'b0;
        byp1_next_s      = 1'b0;
        byp2_next_s      = 1'b0;
        if (mem_stall_s) begin
            writeback_next_s = wb_pulse_s;
        end else begin
            execute_next_s   = 1'b1;
            writeback_next_s = 1'b1;
            fetch_next_s     = !ctrl_busy_s && !raw_bubble_next_s;
            decode_next_s    = !ctrl_trig_s && !raw_bubble_next_s;
            upd_pc_next_s    = (bubble_cnt_next_s <= 3'd1) && !raw_bubble_next_s && complete_instr;
            br_next_s        = (bubble_cnt_next_s == 3'd1) && br_cond_s;
`ifdef LC3_CTRL_BYPASS_EN
            byp1_next_s      = fwd_src1_s && !ctrl_busy_s;
            byp2_next_s      = fwd_src2_s && !ctrl_busy_s;
`else
            byp1_next_s      = 1'b0;
            byp2_next_s      = 1'b0;
`endif
        end
    end

    // Internal state registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_state_r  <= MEM_IDLE;
            mem_served_r <= 1'b0;
            bubble_cnt_r <= 3'd0;
            ctrl_ir_r    <= 7'd0;
            raw_bubble_r <= 1'b0;
        end else begin
            mem_state_r  <= mem_next_s;
            mem_served_r <= mem_served_next_s;
            bubble_cnt_r <= bubble_cnt_next_s;
            ctrl_ir_r    <= ctrl_ir_next_s;
            raw_bubble_r <= raw_bubble_next_s;
        end
    end

    // Registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            enable_updatePC  <= 1'b0;
            enable_fetch     <= 1'b0;
            enable_decode    <= 1'b0;
            enable_execute   <= 1'b0;
            enable_writeback <= 1'b0;
            br_taken         <= 1'b0;
            bypass_alu_1     <= 1'b0;
            bypass_alu_2     <= 1'b0;
        end else begin
            enable_updatePC  <= upd_pc_next_s;
            enable_fetch     <= fetch_next_s;
            enable_decode    <= decode_next_s;
            enable_execute   <= execute_next_s;
            enable_writeback <= writeback_next_s;
            br_taken         <= br_next_s;
            bypass_alu_1     <= byp1_next_s;
            bypass_alu_2     <= byp2_next_s;
        end
    end

endmodule

// File: tb/tb_lc3_pipe_controller.sv
// Self-checking bench for lc3_pipe_controller: directed literal checks plus randomized traffic against a behavioural model.
module tb_lc3_pipe_controller;
    localparam int NB = 4;

    logic        clock, reset, complete_instr, complete_data;
    logic [15:0] IMem_dout, IR, IR_Exec;
    logic [2:0]  psr;
    logic        enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback;
    logic        br_taken, bypass_alu_1, bypass_alu_2;
    logic [1:0]  mem_state;

    int total = 0;
    int bad   = 0;

    // behavioural model state and expected outputs
    logic [1:0]  m_mem;
    int          m_cnt;
    bit          m_served, m_rawb;
    logic [15:0] m_cir;
    bit          e_pc, e_f, e_d, e_x, e_w, e_br, e_b1, e_b2;

    logic [15:0] w;
    logic [3:0]  alu_ops [4] = '{4'h1, 4'h5, 4'h9, 4'hE};

    lc3_pipe_controller #(.CTRL_BUBBLES(NB)) dut (
        .clock(clock), .reset(reset), .complete_instr(complete_instr), .complete_data(complete_data),
        .IMem_dout(IMem_dout), .IR(IR), .IR_Exec(IR_Exec), .psr(psr),
        .enable_updatePC(enable_updatePC), .enable_fetch(enable_fetch), .enable_decode(enable_decode),
        .enable_execute(enable_execute), .enable_writeback(enable_writeback), .br_taken(br_taken),
        .bypass_alu_1(bypass_alu_1), .bypass_alu_2(bypass_alu_2), .mem_state(mem_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_alu(input logic [3:0] op);
        return (op == 4'h1) || (op == 4'h5) || (op == 4'h9) || (op == 4'hE);
    endfunction

    function automatic logic [15:0] en_vec();
        return {11'd0, enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback};
    endfunction

    task automatic model_reset();
        m_mem = 2'd3; m_cnt = 0; m_served = 1'b0; m_rawb = 1'b0; m_cir = 16'h0000;
        {e_pc, e_f, e_d, e_x, e_w, e_br, e_b1, e_b2} = 8'd0;
    endtask

    // Advance one clock: the model reads this cycle's inputs, commits at the edge, then returns 2 time units later.
    task automatic tick();
        logic [1:0]  nxt;
        logic [3:0]  op, fop;
        logic [15:0] cir;
        logic [2:0]  ps;
        bit hold, wb, trig, m1, m2, rb, ci;
        int cnt;
        if (!reset) begin
            @(posedge clock);
            model_reset();
            #2;
        end else begin
            op  = IR_Exec[15:12];
            nxt = m_mem;
            if (m_mem == 2'd3) begin
                if (e_x && !m_served) begin
                    if (op == 4'h2 || op == 4'h6) nxt = 2'd0;
                    else if (op == 4'h3 || op == 4'h7) nxt = 2'd1;
                    else if (op == 4'hA || op == 4'hB) nxt = 2'd2;
                end
            end else if (complete_data) begin
                nxt = (m_mem == 2'd2) ? ((op == 4'hB) ? 2'd1 : 2'd0) : 2'd3;
            end
            hold = (m_mem != 2'd3) || (nxt != 2'd3);
            wb   = (m_mem == 2'd0) && (nxt == 2'd3);
            fop  = IMem_dout[15:12];
            trig = !hold && e_f && complete_instr && (fop == 4'h0 || fop == 4'hC);
            cnt  = m_cnt;
            cir  = m_cir;
            if (trig) begin
                cnt = NB;
                cir = IMem_dout;
            end else if (!hold && cnt > 0) begin
                cnt--;
            end
            m1 = is_alu(IR_Exec[15:12]) && is_alu(IR[15:12]) && (IR[8:6] == IR_Exec[11:9]);
            m2 = is_alu(IR_Exec[15:12]) && (IR[15:12] == 4'h1 || IR[15:12] == 4'h5) &&
                 !IR[5] && (IR[2:0] == IR_Exec[11:9]);
`ifdef LC3_CTRL_BYPASS_EN
            rb = 1'b0;
`else
            rb = (m1 || m2) && !hold && (cnt == 0) && !m_rawb;
`endif
            ci = complete_instr;
            ps = psr;
            @(posedge clock);
            m_served = (m_mem != 2'd3) && (nxt == 2'd3);
            m_mem  = nxt;
            m_cnt  = cnt;
            m_cir  = cir;
            m_rawb = rb;
            if (hold) begin
                {e_pc, e_f, e_d, e_x, e_br, e_b1, e_b2} = 7'd0;
                e_w = wb;
            end else begin
                e_x  = 1'b1;
                e_w  = 1'b1;
                e_f  = (cnt == 0) && !rb;
                e_d  = !trig && !rb;
                e_pc = (cnt <= 1) && !rb && ci;
                e_br = (cnt == 1) && ((cir[15:12] == 4'hC) || (cir[15:12] == 4'h0 && (cir[11:9] & ps) != 3'd0));
`ifdef LC3_CTRL_BYPASS_EN
                e_b1 = m1 && (cnt == 0);
                e_b2 = m2 && (cnt == 0);
`else
                e_b1 = 1'b0;
                e_b2 = 1'b0;
`endif
            end
            #2;
        end
    endtask

    // Every-cycle comparison of all outputs against the model.
    initial begin
        forever begin
            @(negedge clock);
            chk("cycle", {6'd0, enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback,
                          br_taken, bypass_alu_1, bypass_alu_2, mem_state},
                         {6'd0, e_pc, e_f, e_d, e_x, e_w, e_br, e_b1, e_b2, m_mem});
        end
    end

    initial begin
        reset = 1'b0;
        model_reset();
        complete_instr = 1'b1; complete_data = 1'b0;
        IMem_dout = 16'h5000; IR = 16'h0000; IR_Exec = 16'h0000; psr = 3'b000;

        repeat (3) begin
            tick();
            chk("rst_en", en_vec(), 16'h0000);
            chk("rst_mem", {14'd0, mem_state}, 16'h0003);
        end
        reset = 1'b1;
        tick();
        chk("first_en", en_vec(), 16'h001F);
        chk("first_mem", {14'd0, mem_state}, 16'h0003);

        // LD with completion in the third READ cycle
        IR_Exec = 16'h2A05;
        tick(); chk("ld_c1_mem", {14'd0, mem_state}, 16'h0000); chk("ld_c1_en", en_vec(), 16'h0000);
        tick(); chk("ld_c2_mem", {14'd0, mem_state}, 16'h0000);
        tick(); chk("ld_c3_mem", {14'd0, mem_state}, 16'h0000);
        complete_data = 1'b1;
        tick(); chk("ld_c4_mem", {14'd0, mem_state}, 16'h0003); chk("ld_c4_en", en_vec(), 16'h0001);
        complete_data = 1'b0;
        tick(); chk("ld_c5_en", en_vec(), 16'h001F); chk("ld_c5_mem", {14'd0, mem_state}, 16'h0003);
        IR_Exec = 16'h0000;
        tick();

        // STI: INDIRECT -> WRITE -> IDLE
        IR_Exec = 16'hB605;
        tick(); chk("sti_c1_mem", {14'd0, mem_state}, 16'h0002);
        complete_data = 1'b1;
        tick(); chk("sti_c2_mem", {14'd0, mem_state}, 16'h0001);
        complete_data = 1'b0;
        tick(); chk("sti_c3_mem", {14'd0, mem_state}, 16'h0001);
        complete_data = 1'b1;
        tick(); chk("sti_c4_mem", {14'd0, mem_state}, 16'h0003); chk("sti_c4_en", en_vec(), 16'h0000);
        complete_data = 1'b0; IR_Exec = 16'h0000;
        tick(); chk("sti_c5_en", en_vec(), 16'h001F);

        // BRz taken, then not taken
        IMem_dout = 16'h0403; psr = 3'b010;
        tick(); chk("brz_b1_en", en_vec(), 16'h0003); chk("brz_b1_br", {15'd0, br_taken}, 16'h0000);
        IMem_dout = 16'h5000;
        tick(); chk("brz_b2_en", en_vec(), 16'h0007);
        tick(); chk("brz_b3_en", en_vec(), 16'h0007);
        tick(); chk("brz_b4_en", en_vec(), 16'h0017); chk("brz_b4_br", {15'd0, br_taken}, 16'h0001);
        tick(); chk("brz_b5_en", en_vec(), 16'h001F); chk("brz_b5_br", {15'd0, br_taken}, 16'h0000);
        IMem_dout = 16'h0403; psr = 3'b001;
        tick();
        IMem_dout = 16'h5000;
        tick(); tick();
        tick(); chk("brnt_b4_br", {15'd0, br_taken}, 16'h0000); chk("brnt_b4_en", en_vec(), 16'h0017);
        tick();

        // ALU -> ALU dependency on source 1
        IR_Exec = 16'h1261; IR = 16'h1442;
        tick();
`ifdef LC3_CTRL_BYPASS_EN
        chk("fwd_r1_b1", {15'd0, bypass_alu_1}, 16'h0001);
        chk("fwd_r1_b2", {15'd0, bypass_alu_2}, 16'h0000);
        chk("fwd_r1_en", en_vec(), 16'h001F);
`else
        chk("raw_r1_en", en_vec(), 16'h0003);
        chk("raw_r1_b", {14'd0, bypass_alu_1, bypass_alu_2}, 16'h0000);
`endif
        tick();
        chk("raw_r2_en", en_vec(), 16'h001F);
        IR_Exec = 16'h0000; IR = 16'h0000;
        tick();

        // Reset in the middle of a READ
        IR_Exec = 16'h2A05;
        tick(); tick(); chk("mid_c2_mem", {14'd0, mem_state}, 16'h0000);
        #1 reset = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_mem", {14'd0, mem_state}, 16'h0003);
        chk("mid_rst_en", en_vec(), 16'h0000);
        chk("mid_rst_br", {15'd0, br_taken}, 16'h0000);
        IR_Exec = 16'h0000;
        tick();
        reset = 1'b1;
        tick(); chk("mid_after_en", en_vec(), 16'h001F);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (e_x && $urandom_range(0, 2) == 0) begin
                w = 16'($urandom);
                if ($urandom_range(0, 1) == 1) w[15:12] = alu_ops[$urandom_range(0, 3)];
                IR_Exec = w;
            end
            if (e_d && $urandom_range(0, 1) == 1) begin
                w = 16'($urandom);
                if ($urandom_range(0, 3) != 0) w[15:12] = alu_ops[$urandom_range(0, 3)];
                if ($urandom_range(0, 2) == 0) w[8:6] = IR_Exec[11:9];
                if ($urandom_range(0, 2) == 0) w[2:0] = IR_Exec[11:9];
                IR = w;
            end
            w = 16'($urandom);
            if (w[15:12] == 4'h0 || w[15:12] == 4'hC) w[15:12] = 4'h1;
            if ($urandom_range(0, 4) == 0) w[15:12] = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'hC;
            IMem_dout      = w;
            psr            = 3'($urandom_range(0, 7));
            complete_instr = ($urandom_range(0, 7) != 0);
            complete_data  = ($urandom_range(0, 2) == 0);
            if (i % 750 == 749) begin
                reset = 1'b0;
                model_reset();
                tick();
                reset = 1'b1;
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
